// File: rtl/image_sdram_packer_if.sv
// Loader byte bus and SDRAM write-port bus seen by the image packer.
// The master modport is the packer; the slave modport is the loader/controller side.
interface image_sdram_packer_if #(
   parameter int ADDR_WIDTH = 26
);
   logic                  image_download;
   logic                  wr_8bit;
   logic [ADDR_WIDTH-1:0] addr_8bit;
   logic [7:0]            data_8bit;
   logic                  sd_req;
   logic [ADDR_WIDTH-1:0] sd_addr;
   logic [31:0]           sd_data;
   logic [3:0]            sd_be;
   logic                  sd_ack;

   modport master (
      input  image_download, wr_8bit, addr_8bit, data_8bit, sd_ack,
      output sd_req, sd_addr, sd_data, sd_be
   );

   modport slave (
      output image_download, wr_8bit, addr_8bit, data_8bit, sd_ack,
      input  sd_req, sd_addr, sd_data, sd_be
   );
endinterface

// File: rtl/image_sdram_packer.sv
// Packs loader image bytes into 32-bit words with byte enables, queues them in a
// small FIFO and presents the head word to the SDRAM write port over req/ack.
module image_sdram_packer #(
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_WIDTH = 26
) (
   input  logic                  clk,
   input  logic                  reset_n,
   image_sdram_packer_if.master  bus,
   output logic                  busy,
   output logic                  overflow
);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int WW = ADDR_WIDTH - 2;
   localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

   // Control state (reset) and datapath state (not reset)
   logic          prev_dl;
   logic          buf_vld;
   logic [WW-1:0] buf_waddr;
   logic [31:0]   buf_data;
   logic [3:0]    buf_be;

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;

   logic [WW-1:0] mem_waddr [FIFO_DEPTH];
   logic [31:0]   mem_data  [FIFO_DEPTH];
   logic [3:0]    mem_be    [FIFO_DEPTH];

   logic          buf_vld_n;
   logic [WW-1:0] buf_waddr_n;
   logic [31:0]   buf_data_n;
   logic [3:0]    buf_be_n;
   logic          push;
   logic [31:0]   push_data;
   logic [3:0]    push_be;
   logic [WW-1:0] push_waddr;
   logic [31:0]   merged_data;
   logic [3:0]    merged_be;
   logic [31:0]   fresh_data;

   logic          accept;
   logic          flush;
   logic [1:0]    lane;
   logic [4:0]    lane_base;
   logic [3:0]    lane_mask;
   logic [WW-1:0] word_addr;
   logic          same_word;
   logic          pop;
   logic          full;
   logic          push_ok;

   assign accept    = bus.wr_8bit && bus.image_download;
   assign flush     = prev_dl && !bus.image_download && buf_vld;
   assign lane      = bus.addr_8bit[1:0];
   assign lane_base = {lane, 3'b000};
   assign lane_mask = 4'b0001 << lane;
   assign word_addr = bus.addr_8bit[ADDR_WIDTH-1:2];
   assign same_word = (word_addr == buf_waddr);

   assign bus.sd_req = (count != '0);
   assign pop        = bus.sd_ack && bus.sd_req;
   assign full       = (count == FULL_CNT);
   assign push_ok    = push && (!full || pop);

   // Head outputs are gated so they read zero whenever nothing is queued
   assign bus.sd_addr = bus.sd_req ? {mem_waddr[rd_ptr], 2'b00} : '0;
   assign bus.sd_data = bus.sd_req ? mem_data[rd_ptr] : '0;
   assign bus.sd_be   = bus.sd_req ? mem_be[rd_ptr] : '0;
   assign busy        = buf_vld || bus.sd_req;

   always_comb begin
      buf_vld_n   = buf_vld;
      buf_waddr_n = buf_waddr;
      buf_data_n  = buf_data;
      buf_be_n    = buf_be;
      push        = 1'b0;
      push_waddr  = buf_waddr;
      push_data   = buf_data;
      push_be     = buf_be;

      merged_data = buf_data;
      merged_data[lane_base +: 8] = bus.data_8bit;
      merged_be   = buf_be | lane_mask;
      fresh_data  = '0;
      fresh_data[lane_base +: 8] = bus.data_8bit;

      if (accept) begin
         if (buf_vld && same_word) begin
            if (merged_be == 4'hF) begin
               push      = 1'b1;
               push_data = merged_data;
               push_be   = merged_be;
               buf_vld_n = 1'b0;
            end else begin
               buf_data_n = merged_data;
               buf_be_n   = merged_be;
            end
         end else begin
            // A discontinuity evicts the old word; the new byte starts a fresh one
            push        = buf_vld;
            buf_vld_n   = 1'b1;
            buf_waddr_n = word_addr;
            buf_data_n  = fresh_data;
            buf_be_n    = lane_mask;
         end
      end else if (flush) begin
         push      = 1'b1;
         buf_vld_n = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_dl  <= 1'b0;
         buf_vld  <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         prev_dl <= bus.image_download;
         buf_vld <= buf_vld_n;
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (push && !push_ok) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      buf_waddr <= buf_waddr_n;
      buf_data  <= buf_data_n;
      buf_be    <= buf_be_n;
      if (push_ok) begin
         mem_waddr[wr_ptr] <= push_waddr;
         mem_data[wr_ptr]  <= push_data;
         mem_be[wr_ptr]    <= push_be;
      end
   end
endmodule

// File: tb/tb_image_sdram_packer.sv
// Bench for image_sdram_packer: directed vector table, hand-written overflow and
// reset sequences, then randomized traffic against a queue-based reference model.
module tb_image_sdram_packer;
   localparam int AW    = 26;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic reset_n;
   logic busy;
   logic overflow;
   int   checks = 0;
   int   errors = 0;

   image_sdram_packer_if #(.ADDR_WIDTH(AW)) bus ();

   image_sdram_packer #(.FIFO_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .bus      (bus.master),
      .busy     (busy),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          dl;
      logic          wr;
      logic [AW-1:0] a;
      logic [7:0]    d;
      logic          ack;
      logic          req;
      logic [AW-1:0] ea;
      logic [31:0]   ed;
      logic [3:0]    ebe;
      logic          ebusy;
      logic          eovf;
   } vec_t;

   typedef struct {
      logic [AW-3:0] waddr;
      logic [31:0]   data;
      logic [3:0]    be;
   } word_t;

   vec_t vecs[17];

   // Reference model state
   logic          m_vld;
   logic          m_prev;
   logic [AW-3:0] m_waddr;
   logic [7:0]    m_lanes[4];
   logic [3:0]    m_be;
   logic          m_ovf;
   word_t         m_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input logic req, input logic [AW-1:0] a,
                          input logic [31:0] d, input logic [3:0] be, input logic bz,
                          input logic ov);
      chk({tag, ".sd_req"},   32'(bus.sd_req),  32'(req));
      chk({tag, ".sd_addr"},  32'(bus.sd_addr), 32'(a));
      chk({tag, ".sd_data"},  bus.sd_data,      d);
      chk({tag, ".sd_be"},    32'(bus.sd_be),   32'(be));
      chk({tag, ".busy"},     32'(busy),        32'(bz));
      chk({tag, ".overflow"}, 32'(overflow),    32'(ov));
   endtask

   task automatic drive(input logic dl, input logic wr, input logic [AW-1:0] a,
                        input logic [7:0] d, input logic ack);
      bus.image_download = dl;
      bus.wr_8bit        = wr;
      bus.addr_8bit      = a;
      bus.data_8bit      = d;
      bus.sd_ack         = ack;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      drive(1'b0, 1'b0, '0, '0, 1'b0);
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   function automatic word_t model_word();
      word_t w;
      w.waddr = m_waddr;
      w.data  = {m_lanes[3], m_lanes[2], m_lanes[1], m_lanes[0]};
      w.be    = m_be;
      return w;
   endfunction

   function automatic void model_reset();
      m_vld  = 1'b0;
      m_prev = 1'b0;
      m_be   = '0;
      m_ovf  = 1'b0;
      m_q.delete();
      for (int i = 0; i < 4; i++) m_lanes[i] = '0;
   endfunction

   function automatic void model_step(input logic dl, input logic wr, input logic [AW-1:0] a,
                                      input logic [7:0] d, input logic ack);
      logic  do_pop;
      logic  have_push;
      word_t pw;
      do_pop    = ack && (m_q.size() > 0);
      have_push = 1'b0;
      pw        = model_word();
      if (wr && dl) begin
         if (m_vld && a[AW-1:2] != m_waddr) begin
            pw = model_word();
            have_push = 1'b1;
            m_vld = 1'b0;
         end
         if (!m_vld) begin
            m_vld   = 1'b1;
            m_waddr = a[AW-1:2];
            m_be    = '0;
            for (int i = 0; i < 4; i++) m_lanes[i] = '0;
         end
         m_lanes[a[1:0]] = d;
         m_be[a[1:0]]    = 1'b1;
         if (m_be == 4'hF) begin
            pw = model_word();
            have_push = 1'b1;
            m_vld = 1'b0;
         end
      end else if (m_prev && !dl && m_vld) begin
         pw = model_word();
         have_push = 1'b1;
         m_vld = 1'b0;
      end
      m_prev = dl;
      if (do_pop) void'(m_q.pop_front());
      if (have_push) begin
         if (m_q.size() < DEPTH) m_q.push_back(pw);
         else m_ovf = 1'b1;
      end
   endfunction

   task automatic chk_model(input string tag);
      word_t h;
      if (m_q.size() > 0) begin
         h = m_q[0];
         chk_all(tag, 1'b1, {h.waddr, 2'b00}, h.data, h.be, 1'b1, m_ovf);
      end else begin
         chk_all(tag, 1'b0, '0, '0, '0, m_vld, m_ovf);
      end
   endtask

   initial begin
      logic [AW-1:0] cursor;
      logic [AW-1:0] a;
      logic          dl;
      logic          wr;
      logic          ack;
      logic [7:0]    d;
      int            dl_low;

      vecs[0]  = '{1'b1, 1'b1, 26'h00, 8'h11, 1'b0, 1'b0, 26'h00, 32'h0, 4'h0, 1'b1, 1'b0};
      vecs[1]  = '{1'b1, 1'b1, 26'h01, 8'h22, 1'b0, 1'b0, 26'h00, 32'h0, 4'h0, 1'b1, 1'b0};
      vecs[2]  = '{1'b1, 1'b1, 26'h02, 8'h33, 1'b0, 1'b0, 26'h00, 32'h0, 4'h0, 1'b1, 1'b0};
      vecs[3]  = '{1'b1, 1'b1, 26'h03, 8'h44, 1'b0, 1'b1, 26'h00, 32'h44332211, 4'hF, 1'b1, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 26'h00, 8'h00, 1'b1, 1'b0, 26'h00, 32'h0, 4'h0, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 1'b1, 26'h04, 8'hAA, 1'b0, 1'b0, 26'h00, 32'h0, 4'h0, 1'b1, 1'b0};
      vecs[6]  = '{1'b1, 1'b1, 26'h05, 8'hBB, 1'b0, 1'b0, 26'h00, 32'h0, 4'h0, 1'b1, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 26'h00, 8'h00, 1'b0, 1'b1, 26'h04, 32'h0000BBAA, 4'h3, 1'b1, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 26'h00, 8'h00, 1'b1, 1'b0, 26'h00, 32'h0, 4'h0, 1'b0, 1'b0};
      vecs[9]  = '{1'b1, 1'b1, 26'h0A, 8'h5A, 1'b0, 1'b0, 26'h00, 32'h0, 4'h0, 1'b1, 1'b0};
      vecs[10] = '{1'b1, 1'b1, 26'h20, 8'h77, 1'b0, 1'b1, 26'h08, 32'h005A0000, 4'h4, 1'b1, 1'b0};
      vecs[11] = '{1'b1, 1'b0, 26'h00, 8'h00, 1'b1, 1'b0, 26'h00, 32'h0, 4'h0, 1'b1, 1'b0};
      vecs[12] = '{1'b0, 1'b0, 26'h00, 8'h00, 1'b0, 1'b1, 26'h20, 32'h00000077, 4'h1, 1'b1, 1'b0};
      vecs[13] = '{1'b0, 1'b0, 26'h00, 8'h00, 1'b1, 1'b0, 26'h00, 32'h0, 4'h0, 1'b0, 1'b0};
      vecs[14] = '{1'b0, 1'b1, 26'h00, 8'hFF, 1'b0, 1'b0, 26'h00, 32'h0, 4'h0, 1'b0, 1'b0};
      vecs[15] = '{1'b0, 1'b1, 26'h03, 8'hEE, 1'b0, 1'b0, 26'h00, 32'h0, 4'h0, 1'b0, 1'b0};
      vecs[16] = '{1'b0, 1'b0, 26'h00, 8'h00, 1'b1, 1'b0, 26'h00, 32'h0, 4'h0, 1'b0, 1'b0};

      reset_n = 1'b0;
      drive(1'b0, 1'b0, '0, '0, 1'b0);
      @(negedge clk);
      chk_all("reset", 1'b0, '0, '0, '0, 1'b0, 1'b0);
      do_reset();

      foreach (vecs[i]) begin
         drive(vecs[i].dl, vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].ack);
         tick();
         chk_all($sformatf("vec%0d", i), vecs[i].req, vecs[i].ea, vecs[i].ed, vecs[i].ebe,
                 vecs[i].ebusy, vecs[i].eovf);
      end

      // Five full words with no acks: the fifth must be dropped
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 1'b1, AW'(i), 8'(i), 1'b0);
         tick();
      end
      drive(1'b1, 1'b0, '0, '0, 1'b0);
      tick();
      chk_all("ovf_full", 1'b1, 26'h0, 32'h03020100, 4'hF, 1'b1, 1'b1);
      for (int n = 0; n < 4; n++) begin
         chk($sformatf("ovf_pop%0d.addr", n), 32'(bus.sd_addr), 32'(4 * n));
         chk($sformatf("ovf_pop%0d.data", n), bus.sd_data,
             {8'(4 * n + 3), 8'(4 * n + 2), 8'(4 * n + 1), 8'(4 * n)});
         bus.sd_ack = 1'b1;
         tick();
      end
      bus.sd_ack = 1'b0;
      chk_all("ovf_drained", 1'b0, '0, '0, '0, 1'b0, 1'b1);

      // Asynchronous reset with two queued words and a partial buffer
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, 1'b1, AW'(i), 8'(8'h80 + i), 1'b0);
         tick();
      end
      drive(1'b1, 1'b0, '0, '0, 1'b0);
      chk_all("pre_rst", 1'b1, 26'h0, 32'h83828180, 4'hF, 1'b1, 1'b1);
      #2 reset_n = 1'b0;
      #1 chk_all("mid_rst", 1'b0, '0, '0, '0, 1'b0, 1'b0);
      @(negedge clk);
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, AW'(8'h40 + i), 8'(8'hA0 + i), 1'b0);
         tick();
      end
      drive(1'b1, 1'b0, '0, '0, 1'b0);
      chk_all("post_rst", 1'b1, 26'h40, 32'hA3A2A1A0, 4'hF, 1'b1, 1'b0);
      bus.sd_ack = 1'b1;
      tick();
      bus.sd_ack = 1'b0;
      chk_all("post_rst_ack", 1'b0, '0, '0, '0, 1'b0, 1'b0);

      // Randomized traffic against the reference model
      do_reset();
      model_reset();
      cursor = '0;
      dl_low = 0;
      for (int c = 0; c < 3000; c++) begin
         if (dl_low > 0) begin
            dl = 1'b0;
            dl_low--;
         end else if ($urandom_range(0, 99) < 4) begin
            dl = 1'b0;
            dl_low = $urandom_range(0, 2);
         end else begin
            dl = 1'b1;
         end
         wr  = ($urandom_range(0, 99) < 70);
         ack = ($urandom_range(0, 99) < (c < 1500 ? 55 : 85));
         d   = 8'($urandom);
         case ($urandom_range(0, 19))
            0, 1:    a = AW'($urandom_range(0, 255));
            2, 3:    a = {cursor[AW-1:2], 2'($urandom)};
            default: begin
               a = cursor;
               if (wr) cursor = cursor + 1'b1;
            end
         endcase
         drive(dl, wr, a, d, ack);
         model_step(dl, wr, a, d, ack);
         tick();
         chk_model($sformatf("rnd%0d", c));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
